// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared loader states, word geometry and checksum width
package program_loader_pkg;
  typedef enum logic [2:0] {IDLE, HEADER, COLLECT, WRITE, CHECK, DONE, ERROR} state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int CSUM_W = 8;
endpackage

// File: rtl/word_assembler.sv
// word_assembler: big-endian byte-to-word shift register with byte counter
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_last
);
  localparam int CW = $clog2(BYTES_PER_WORD);
  logic [CW-1:0] r_cnt;
  logic [23:0]   r_sh;
  // o_word already includes the byte being accepted, so the top can latch it on the 4th byte
  assign o_word = {r_sh, i_byte};
  assign o_last = i_accept && (r_cnt == CW'(BYTES_PER_WORD - 1));
  // shift accepted bytes in from the bottom; counter wraps at each full word
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
      r_sh  <= '0;
    end else if (i_accept) begin
      r_cnt <= r_cnt + 1'b1;
      r_sh  <= o_word[23:0];
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams header, instruction words and checksum into program memory
module program_loader
  import program_loader_pkg::*;
#(
  parameter int MEMORY_DEPTH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [7:0]  ByteIn,
  input  logic        ByteValid,
  output logic        ByteReady,
  output logic        MemWrite,
  output logic [31:0] MemAddress,
  output logic [31:0] MemData,
  output logic        Loading,
  output logic        Done,
  output logic        Error
);
  localparam logic [31:0] DEPTH = 32'(MEMORY_DEPTH);
  state_t            r_state;
  logic [7:0]        r_count;
  logic [7:0]        r_index;
  logic [CSUM_W-1:0] r_csum;
  logic              w_accept;
  logic              w_clear;
  logic              w_last;
  logic [31:0]       w_word;
  logic [7:0]        w_index_nx;
  assign ByteReady  = r_state inside {HEADER, COLLECT, CHECK};
  assign Loading    = r_state inside {HEADER, COLLECT, WRITE, CHECK};
  assign w_accept   = ByteValid && ByteReady;
  assign w_clear    = Start && (r_state inside {IDLE, DONE, ERROR});
  assign w_index_nx = r_index + 8'd1;
  word_assembler u_asm (
    .clk      (clk),
    .rst_n    (reset),
    .i_clear  (w_clear),
    .i_accept (w_accept && r_state == COLLECT),
    .i_byte   (ByteIn),
    .o_word   (w_word),
    .o_last   (w_last)
  );
  // session FSM; memory port and status flags are registered here
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_index    <= '0;
      r_csum     <= '0;
      MemWrite   <= 1'b0;
      MemAddress <= '0;
      MemData    <= '0;
      Done       <= 1'b0;
      Error      <= 1'b0;
    end else begin
      MemWrite <= 1'b0;
      case (r_state)
        IDLE, DONE, ERROR:
          if (Start) begin
            r_state <= HEADER;
            r_index <= '0;
            r_csum  <= '0;
            Done    <= 1'b0;
            Error   <= 1'b0;
          end
        HEADER:
          if (w_accept) begin
            r_count <= ByteIn;
            r_csum  <= ByteIn;
            if (ByteIn == 8'd0 || 32'(ByteIn) > DEPTH) begin
              r_state <= ERROR;
              Error   <= 1'b1;
            end else r_state <= COLLECT;
          end
        COLLECT:
          if (w_accept) begin
            r_csum <= r_csum ^ ByteIn;
            if (w_last) begin
              r_state    <= WRITE;
              MemWrite   <= 1'b1;
              MemData    <= w_word;
              MemAddress <= {22'd0, r_index, 2'b00};
            end
          end
        WRITE: begin
          r_index <= w_index_nx;
          r_state <= (w_index_nx < r_count) ? COLLECT : CHECK;
        end
        CHECK:
          if (w_accept) begin
            r_state <= (ByteIn == r_csum) ? DONE : ERROR;
            Done    <= (ByteIn == r_csum);
            Error   <= (ByteIn != r_csum);
          end
        default: r_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: randomized load sessions checked against a stream-level model
module tb_program_loader;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        Start = 1'b0;
  logic [7:0]  ByteIn = 8'd0;
  logic        ByteValid = 1'b0;
  logic        ByteReady, MemWrite, Loading, Done, Error;
  logic [31:0] MemAddress, MemData;
  int          checks = 0;
  int          failures = 0;
  int          pulse_err = 0;
  logic        prev_mw = 1'b0;
  logic [63:0] wq[$];
  logic [31:0] fixed[$];

  always #5 clk = ~clk;

  program_loader #(.MEMORY_DEPTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .ByteIn     (ByteIn),
    .ByteValid  (ByteValid),
    .ByteReady  (ByteReady),
    .MemWrite   (MemWrite),
    .MemAddress (MemAddress),
    .MemData    (MemData),
    .Loading    (Loading),
    .Done       (Done),
    .Error      (Error)
  );

  // record every write strobe and flag strobes lasting more than one cycle
  always @(negedge clk) begin
    if (MemWrite) begin
      if (prev_mw) pulse_err++;
      wq.push_back({MemAddress, MemData});
    end
    prev_mw = MemWrite;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) Start = 1'b1;
    @(negedge clk) Start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin
      ByteIn = 8'($urandom);
      @(negedge clk);
    end
    ByteIn = b;
    ByteValid = 1'b1;
    while (!ByteReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!ByteReady) chk("ready_wait", ByteReady, 1);
    @(posedge clk);
    @(negedge clk);
    ByteValid = 1'b0;
    ByteIn = 8'($urandom);
  endtask

  // one full session: expected writes and outcome come from the byte-stream rules
  task automatic load(input logic [7:0] n, input int cs_force, input bit gaps, input bit mid_start, input string tag);
    logic [7:0]  cs, bv;
    logic [31:0] w;
    logic [63:0] ew[$];
    bit          ok, good;
    wq.delete();
    pulse_err = 0;
    ok = (n != 8'd0) && (n <= 8'd32);
    good = 1'b0;
    pulse_start();
    chk({tag, "_loading_start"}, {Loading, Done, Error}, 3'b100);
    send(n, 1'b0);
    cs = n;
    if (ok) begin
      for (int i = 0; i < int'(n); i++) begin
        w = (i < fixed.size()) ? fixed[i] : $urandom;
        ew.push_back({32'(i * 4), w});
        for (int k = 0; k < 4; k++) begin
          bv = w[31 - 8 * k -: 8];
          cs ^= bv;
          send(bv, gaps);
          if (mid_start && i == 0 && k == 1) pulse_start();
        end
      end
      good = (cs_force < 0) || (8'(cs_force) == cs);
      send((cs_force < 0) ? cs : 8'(cs_force), gaps);
    end
    chk({tag, "_nwrites"}, wq.size(), ew.size());
    for (int i = 0; i < ew.size() && i < wq.size(); i++) chk({tag, "_write"}, wq[i], ew[i]);
    chk({tag, "_done"}, Done, ok && good);
    chk({tag, "_error"}, Error, !(ok && good));
    chk({tag, "_idle_outs"}, {Loading, ByteReady}, 2'b00);
    chk({tag, "_strobe_width"}, pulse_err, 0);
    if (ok) chk({tag, "_mem_hold"}, {MemAddress, MemData}, ew[ew.size() - 1]);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_outs", {ByteReady, MemWrite, MemAddress, MemData, Loading, Done, Error}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("idle_outs", {ByteReady, MemWrite, Loading, Done, Error}, 0);
    fixed = '{32'h20080005, 32'h20090007};
    load(8'd2, -1, 1'b0, 1'b0, "basic");
    load(8'd0, -1, 1'b0, 1'b0, "hdr00");
    load(8'h21, -1, 1'b0, 1'b0, "hdr21");
    load(8'd2, 8'hFF, 1'b0, 1'b0, "badcs");
    load(8'd2, -1, 1'b1, 1'b0, "gaps");
    load(8'd2, -1, 1'b0, 1'b1, "midstart");
    wq.delete();
    pulse_start();
    send(8'd2, 1'b0);
    send(8'h20, 1'b0);
    send(8'h08, 1'b0);
    send(8'h00, 1'b0);
    send(8'h05, 1'b0);
    send(8'h20, 1'b0);
    #2 reset = 1'b0;
    #1 chk("midrst_outs", {ByteReady, MemWrite, MemAddress, MemData, Loading, Done, Error}, 0);
    ByteValid = 1'b1;
    repeat (6) begin
      ByteIn = 8'($urandom);
      @(negedge clk);
    end
    ByteValid = 1'b0;
    chk("midrst_nwrites", wq.size(), 1);
    chk("midrst_hold", {ByteReady, MemWrite, MemAddress, MemData, Loading, Done, Error}, 0);
    reset = 1'b1;
    load(8'd2, -1, 1'b0, 1'b0, "after_rst");
    fixed.delete();
    repeat (6) load(8'($urandom_range(1, 5)), ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : -1, 1'b1, 1'b0, "rand");
    load(8'd32, -1, 1'b0, 1'b0, "full");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
